score_bcd_converter: RTL
========================

Name: score_bcd_converter

Overview:
- Sequential double-dabble converter that takes the binary game score from the ball/game-logic stage and produces packed BCD digits.
- Its output drives the HexDriver instances on HEX0..HEX4, so the score shows on the board's seven-segment displays.
- Conversion is launched once per video frame, or on demand, and outputs update atomically so displays never show a half-converted value.

Parameters:
- WIDTH, 10, bit width of the binary score input.
- DIGITS, 4, number of BCD output digits (4 bits each).

Ports:
- Clk  input  1  50 MHz system clock (MAX10_CLK1_50).
- Reset_n  input  1  asynchronous, active-low reset.
- frame_clk  input  1  VGA vertical sync from another timing domain. Synchronised internally; each rising edge requests a conversion.
- update  input  1  single-cycle synchronous conversion request.
- score  input  WIDTH  unsigned binary score, sampled at conversion start.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits [3:0].
- valid  output  1  high once at least one conversion has completed since reset.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high when the last converted score exceeded 10^DIGITS-1.
- blank  output  DIGITS  per-digit leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (asynchronous on Reset_n low): state=IDLE; bcd=0, valid=0, busy=0, ovf=0, blank=0; pending=0; synchroniser flops=0.
- frame_clk handling:
  - Passes through a 2-flop synchroniser, then a third flop for edge detection.
  - A rising edge produces a one-cycle req pulse, 3 Clk cycles after the edge at the pin.
- start = req | update.
- State IDLE:
  - On start: latch score into shift_reg, clear the BCD scratch, load iteration counter cnt=WIDTH-1, go to SHIFT, busy=1.
- State SHIFT (one iteration per cycle):
  - First, every scratch digit >=5 gets +3.
  - Then {scratch, shift_reg} shifts left by 1.
  - cnt decrements; when cnt==0, go to DONE.
- State DONE (one cycle):
  - Register scratch into bcd; valid=1; busy=0; update ovf and blank.
  - If pending=1: clear pending and restart directly (same actions as IDLE start). Otherwise go to IDLE.
- Latency: start cycle to bcd update = WIDTH+1 cycles (11 with defaults). busy is high for WIDTH+1 cycles.
- start while busy: not dropped. Sets pending=1; multiple requests collapse into one. The re-run samples score at restart time.
- start coincident with DONE: counts as pending and restarts immediately.
- Overflow:
  - If the latched score > 10^DIGITS-1: bcd saturates to all 9s and ovf=1; otherwise ovf=0.
  - The comparison is computed at start.
  - With the defaults this is unreachable (1023 < 9999) but must be implemented.
- Scratch width is 4*DIGITS bits. Carry out of the top digit is discarded; the saturation path covers it.
- Reset mid-conversion: immediate return to IDLE with all outputs zero; pending is cleared.
- bcd/ovf/blank change only in DONE and are stable between conversions.

Optional Feature:
- Macro: SCORE_BCD_BLANK_EN.
- Defined:
  - blank[i]=1 for every digit i>0 that is 0 and has all higher digits 0.
  - blank[0] is never set. Example: score 7 -> blank=4'b1110.
  - Updated in DONE.
- Undefined: blank is constant 0 and no blanking logic is generated.

Decomposition:
- Package score_bcd_pkg:
  - typedef enum of state_t {IDLE, SHIFT, DONE};
  - function add3_fix(4-bit digit);
  - localparam for the BCD max (all 9s pattern) derived from DIGITS.
- One sub-module: edge_sync. Holds the 2-flop synchroniser plus rising-edge detector for frame_clk, with the same Clk/Reset_n convention; reusable for other VGA_VS consumers.

Test Plan:
- Reset_n low at t0, then release -> bcd=16'h0000, valid=0, busy=0, ovf=0, blank=0.
- score=10'd1023, pulse update -> busy high for 11 cycles, then bcd=16'h1023, valid=1, ovf=0.
- score=10'd0, toggle frame_clk rising -> after 3+11 cycles bcd=16'h0000; with SCORE_BCD_BLANK_EN, blank=4'b1110.
- score=10'd7, update; at cycle 4 set score=10'd512 and pulse update twice -> first result 16'h0007, then one re-run gives 16'h0512. Exactly two DONE cycles.
- WIDTH=14, DIGITS=4, score=14'd12000, update -> bcd=16'h9999, ovf=1. Then score=14'd42 -> bcd=16'h0042, ovf=0.
- Start a conversion with score=10'd999; assert Reset_n low at cycle 5 -> outputs zero immediately. After release, no stale DONE occurs and busy=0.

Source files
------------

// File: rtl/score_bcd_converter_pkg.sv
// Shared types and helpers for the score-to-BCD converter.
// Holds the FSM state type, the double-dabble digit correction and the
// constants used for overflow saturation.
package score_bcd_pkg;

    // Widest digit count the helper functions can describe.
    localparam int MAX_DIGITS = 16;
    localparam int NIBBLES_W  = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Double-dabble correction: a digit of 5 or more gets +3 before the shift
    function automatic logic [3:0] add3_fix(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

    // Packed BCD pattern of all 9s for the given digit count (the saturation value)
    function automatic logic [NIBBLES_W-1:0] bcd_all_nines(input int digits);
        logic [NIBBLES_W-1:0] pattern;
        pattern = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                pattern[4*i +: 4] = 4'd9;
            end
        end
        return pattern;
    endfunction

    // Largest decimal value representable with the given digit count (10^digits - 1)
    function automatic logic [63:0] dec_max(input int digits);
        logic [63:0] value;
        value = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                value = (value * 64'd10) + 64'd9;
            end
        end
        return value;
    endfunction

endpackage

// File: rtl/score_bcd_converter_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a slow asynchronous
// strobe such as VGA vertical sync. rise_o is a one-cycle pulse that appears
// combinationally from the third flop, so the consumer samples it on the third
// clock edge after the pin edge.
module edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic sig_i,
    output logic rise_o
);

    logic meta_q;
    logic stable_q;
    logic delayed_q;

    // Shift the asynchronous input through the synchroniser and the edge-detect flop
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q    <= 1'b0;
            stable_q  <= 1'b0;
            delayed_q <= 1'b0;
        end else begin
            meta_q    <= sig_i;
            stable_q  <= meta_q;
            delayed_q <= stable_q;
        end
    end

    assign rise_o = stable_q & ~delayed_q;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter from the binary game score to packed BCD
// for the seven-segment HexDrivers. A conversion starts on a synchronised
// frame_clk rising edge or on an update pulse; results land in bcd/ovf/blank
// together in the DONE cycle so the display never shows a partial value.
// Optional feature: define SCORE_BCD_BLANK_EN to generate the leading-zero
// blank mask; without it blank is tied to zero.
module score_bcd_converter
    import score_bcd_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic                  update,
    input  logic [WIDTH-1:0]      score,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  busy,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int XW = (WIDTH > 64) ? WIDTH : 64;

    localparam logic [NIBBLES_W-1:0] ALL_NINES = bcd_all_nines(DIGITS);
    localparam logic [SW-1:0]        BCD_MAX   = ALL_NINES[SW-1:0];
    localparam logic [63:0]          DEC_MAX   = dec_max(DIGITS);

    state_t            state_q;
    logic [WIDTH-1:0]  shift_q;
    logic [SW-1:0]     scratch_q;
    logic [CW-1:0]     cnt_q;
    logic              pending_q;
    logic              sat_q;
    logic [SW-1:0]     bcd_q;
    logic              valid_q;
    logic              busy_q;
    logic              ovf_q;

    logic              frameReq;
    logic              start;
    logic              overflow_d;
    logic [SW-1:0]     fixed;
    logic [SW-1:0]     scratch_d;
    logic [WIDTH-1:0]  shift_d;
    logic [SW-1:0]     result_d;

    edge_sync u_frame_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .sig_i   (frame_clk),
        .rise_o  (frameReq)
    );

    assign start = frameReq | update;

    // Out-of-range check on the live score, captured alongside it at each start
    assign overflow_d = (XW'(score) > XW'(DEC_MAX));

    // One double-dabble step: correct every digit, then shift scratch and binary together;
    // the carry out of the top digit is dropped because saturation covers that case
    always_comb begin
        fixed = '0;
        for (int i = 0; i < DIGITS; i++) begin
            fixed[4*i +: 4] = add3_fix(scratch_q[4*i +: 4]);
        end
        {scratch_d, shift_d} = {fixed, shift_q} << 1;
        result_d = sat_q ? BCD_MAX : scratch_q;
    end

    // Conversion FSM; all outputs are registered and only change in DONE (busy on start/finish)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            sat_q     <= 1'b0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= score;
                        scratch_q <= '0;
                        cnt_q     <= CW'(WIDTH - 1);
                        sat_q     <= overflow_d;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q - 1'b1;
                    if (start) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= result_d;
                    ovf_q   <= sat_q;
                    valid_q <= 1'b1;
                    if (pending_q || start) begin
                        pending_q <= 1'b0;
                        shift_q   <= score;
                        scratch_q <= '0;
                        cnt_q     <= CW'(WIDTH - 1);
                        sat_q     <= overflow_d;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCORE_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;
    logic              leadZero;

    // Blank each non-ones digit that is zero with only zeros above it
    always_comb begin
        blank_d  = '0;
        leadZero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            leadZero   = leadZero & (result_d[4*i +: 4] == 4'd0);
            blank_d[i] = leadZero;
        end
    end

    // Capture the blank mask together with the digits in DONE
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_q <= '0;
        end else if (state_q == DONE) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign ovf   = ovf_q;

endmodule
